// File: rtl/huffman_pkg.sv
// rtl/huffman_pkg.sv - shared types, default sizes and width helpers for huffman_gen
//   huff_state_e     : encoder FSM states
//   HUFF_*           : default alphabet / data / counter / code widths
//   huff_weight_w()  : merged-weight width (counter width plus growth for summing all symbols)
//   huff_idx_w()     : width of a symbol index
//   huff_sym_lo()    : low bit of symbol k (1-based) inside a packed per-symbol bus
package huffman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REC     = 3'd1,
    ST_CNT_OUT = 3'd2,
    ST_SCAN    = 3'd3,
    ST_MERGE   = 3'd4,
    ST_DONE    = 3'd5
  } huff_state_e;

  localparam int HUFF_NUM_SYM = 6;
  localparam int HUFF_DATA_W  = 8;
  localparam int HUFF_CNT_W   = 8;
  localparam int HUFF_CODE_W  = 8;

  function automatic int huff_weight_w(input int cnt_w, input int num_sym);
    return cnt_w + $clog2(num_sym);
  endfunction

  function automatic int huff_idx_w(input int num_sym);
    return (num_sym > 1) ? $clog2(num_sym) : 1;
  endfunction

  function automatic int huff_sym_lo(input int k, input int w);
    return (k - 1) * w;
  endfunction

endpackage

// File: rtl/huffman_if.sv
// rtl/huffman_if.sv - sample stream in, counts/codes out, for huffman_gen
//   gray_valid/gray_data : sample strobe and value (source -> encoder)
//   CNT_valid/CNT        : per-symbol counts pulse and bus (encoder -> sink)
//   code_valid/HC/M      : per-symbol code and mask pulse and buses (encoder -> sink)
//   busy                 : encoder is inside a frame
//   modport slave is the encoder side, modport master the source/sink side
interface huffman_if #(
  parameter int NUM_SYM = 6,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int CODE_W  = 8
);

  logic                      gray_valid;
  logic [DATA_W-1:0]         gray_data;
  logic                      CNT_valid;
  logic [NUM_SYM*CNT_W-1:0]  CNT;
  logic                      code_valid;
  logic [NUM_SYM*CODE_W-1:0] HC;
  logic [NUM_SYM*CODE_W-1:0] M;
  logic                      busy;

  modport master (
    output gray_valid, gray_data,
    input  CNT_valid, CNT, code_valid, HC, M, busy
  );

  modport slave (
    input  gray_valid, gray_data,
    output CNT_valid, CNT, code_valid, HC, M, busy
  );

endinterface

// File: rtl/huffman_min2_scan.sv
// rtl/huffman_min2_scan.sv - sequential tracker of the two smallest active entries
//   clk, reset        : clock, asynchronous active-high reset
//   start_i           : clear the tracker before a new pass
//   step_i            : present one entry (index_i, weight_i, active_i) this cycle
//   min1_o / min2_o   : index of the smallest / second smallest active entry so far
//   found_o           : number of active entries seen so far, saturating at 2
// Ordering: a precedes b when its weight is lower, or weights tie and its index is higher.
module huffman_min2_scan #(
  parameter int IDX_W = 3,
  parameter int WGT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [WGT_W-1:0] weight_i,
  input  logic             active_i,
  output logic [IDX_W-1:0] min1_o,
  output logic [IDX_W-1:0] min2_o,
  output logic [1:0]       found_o
);

  logic [IDX_W-1:0] min1_q, min1_d, min2_q, min2_d;
  logic [WGT_W-1:0] min1_w_q, min1_w_d, min2_w_q, min2_w_d;
  logic [1:0]       found_q, found_d;

  function automatic logic precedes(input logic [WGT_W-1:0] wa, input logic [IDX_W-1:0] ia,
                                    input logic [WGT_W-1:0] wb, input logic [IDX_W-1:0] ib);
    return (wa < wb) || ((wa == wb) && (ia > ib));
  endfunction

  always_comb begin
    min1_d   = min1_q;
    min1_w_d = min1_w_q;
    min2_d   = min2_q;
    min2_w_d = min2_w_q;
    found_d  = found_q;
    if (start_i) begin
      min1_d   = '0;
      min1_w_d = '0;
      min2_d   = '0;
      min2_w_d = '0;
      found_d  = 2'd0;
    end else if (step_i && active_i) begin
      if (found_q == 2'd0) begin
        min1_d   = index_i;
        min1_w_d = weight_i;
        found_d  = 2'd1;
      end else begin
        if (precedes(weight_i, index_i, min1_w_q, min1_q)) begin
          // new overall minimum pushes the old one down to second place
          min2_d   = min1_q;
          min2_w_d = min1_w_q;
          min1_d   = index_i;
          min1_w_d = weight_i;
        end else if ((found_q == 2'd1) || precedes(weight_i, index_i, min2_w_q, min2_q)) begin
          min2_d   = index_i;
          min2_w_d = weight_i;
        end
        found_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min1_q   <= '0;
      min1_w_q <= '0;
      min2_q   <= '0;
      min2_w_q <= '0;
      found_q  <= 2'd0;
    end else begin
      min1_q   <= min1_d;
      min1_w_q <= min1_w_d;
      min2_q   <= min2_d;
      min2_w_q <= min2_w_d;
      found_q  <= found_d;
    end
  end

  assign min1_o  = min1_q;
  assign min2_o  = min2_q;
  assign found_o = found_q;

endmodule

// File: rtl/huffman_gen.sv
// rtl/huffman_gen.sv - per-frame symbol histogram and Huffman code builder
//   clk, reset : clock, asynchronous active-high reset
//   bus        : huffman_if.slave - gray_valid/gray_data in; CNT_valid/CNT,
//                code_valid/HC/M and busy out
// Build option: HUFF_CNT_SAT_EN makes symbol counters saturate instead of wrapping.
module huffman_gen
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = HUFF_NUM_SYM,
  parameter int DATA_W  = HUFF_DATA_W,
  parameter int CNT_W   = HUFF_CNT_W,
  parameter int CODE_W  = HUFF_CODE_W
) (
  input logic      clk,
  input logic      reset,
  huffman_if.slave bus
);

  localparam int WGT_W = huff_weight_w(CNT_W, NUM_SYM);
  localparam int IDX_W = huff_idx_w(NUM_SYM);
  localparam int LEN_W = $clog2(CODE_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

  huff_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q [NUM_SYM];
  logic [WGT_W-1:0]  wgt_q [NUM_SYM];
  logic [IDX_W-1:0]  grp_q [NUM_SYM];   // leader index of each symbol's group
  logic [LEN_W-1:0]  len_q [NUM_SYM];
  logic [CODE_W-1:0] hc_q  [NUM_SYM];
  logic [CODE_W-1:0] m_q   [NUM_SYM];
  logic [IDX_W-1:0]  idx_q;

  logic [NUM_SYM-1:0] hit;
  logic               scan_start, scan_step;
  logic               cur_active, two_found;
  logic [WGT_W-1:0]   cur_wgt;
  logic [IDX_W-1:0]   min1, min2, new_leader;
  logic [1:0]         found;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef HUFF_CNT_SAT_EN
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  // (1 << n) - 1, with n up to CODE_W
  function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] n);
    return CODE_W'(((CODE_W + 1)'(1) << n) - (CODE_W + 1)'(1));
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_SYM; k++) begin
      hit[k] = bus.gray_valid && (bus.gray_data == DATA_W'(k + 1));
    end
  end

  // A leader is a symbol that still heads its own group and carries weight.
  assign cur_wgt    = wgt_q[idx_q];
  assign cur_active = (grp_q[idx_q] == idx_q) && (cur_wgt != '0);
  // The tracker registers the last entry one cycle late, so fold it in here
  // to decide between another merge and finishing on the final scan cycle.
  assign two_found  = (found == 2'd2) || ((found == 2'd1) && cur_active);
  assign new_leader = (min1 < min2) ? min1 : min2;

  huffman_min2_scan #(
    .IDX_W(IDX_W),
    .WGT_W(WGT_W)
  ) u_min2_scan (
    .clk     (clk),
    .reset   (reset),
    .start_i (scan_start),
    .step_i  (scan_step),
    .index_i (idx_q),
    .weight_i(cur_wgt),
    .active_i(cur_active),
    .min1_o  (min1),
    .min2_o  (min2),
    .found_o (found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    scan_start     = 1'b0;
    scan_step      = 1'b0;
    bus.CNT_valid  = 1'b0;
    bus.code_valid = 1'b0;
    bus.busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (bus.gray_valid) state_d = ST_REC;
      end
      ST_REC: begin
        if (!bus.gray_valid) state_d = ST_CNT_OUT;
      end
      ST_CNT_OUT: begin
        bus.CNT_valid = 1'b1;
        scan_start    = 1'b1;
        state_d       = ST_SCAN;
      end
      ST_SCAN: begin
        scan_step = 1'b1;
        if (idx_q == LAST_IDX) state_d = two_found ? ST_MERGE : ST_DONE;
      end
      ST_MERGE: begin
        scan_start = 1'b1;
        state_d    = ST_SCAN;
      end
      ST_DONE: begin
        bus.code_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      for (int k = 0; k < NUM_SYM; k++) begin
        cnt_q[k] <= '0;
        wgt_q[k] <= '0;
        grp_q[k] <= '0;
        len_q[k] <= '0;
        hc_q[k]  <= '0;
        m_q[k]   <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.gray_valid) begin
            for (int k = 0; k < NUM_SYM; k++) begin
              cnt_q[k] <= hit[k] ? CNT_W'(1) : '0;
              len_q[k] <= '0;
              hc_q[k]  <= '0;
              m_q[k]   <= '0;
            end
          end
        end
        ST_REC: begin
          for (int k = 0; k < NUM_SYM; k++) begin
            if (hit[k]) cnt_q[k] <= cnt_inc(cnt_q[k]);
          end
        end
        ST_CNT_OUT: begin
          idx_q <= '0;
          for (int k = 0; k < NUM_SYM; k++) begin
            grp_q[k] <= IDX_W'(k);
            wgt_q[k] <= WGT_W'(cnt_q[k]);
            // Active symbols start with a 1-bit mask: this is the final mask when
            // a symbol is alone, and any merge rewrites it from len otherwise.
            m_q[k]   <= (cnt_q[k] != '0) ? CODE_W'(1) : '0;
          end
        end
        ST_SCAN: begin
          idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        ST_MERGE: begin
          wgt_q[new_leader] <= wgt_q[min1] + wgt_q[min2];
          for (int k = 0; k < NUM_SYM; k++) begin
            if ((grp_q[k] == min1) || (grp_q[k] == min2)) begin
              // min1's members take a 1 at their next bit, min2's keep the cleared 0
              if (grp_q[k] == min1) hc_q[k] <= hc_q[k] | (CODE_W'(1) << len_q[k]);
              len_q[k] <= len_q[k] + LEN_W'(1);
              m_q[k]   <= len_mask(len_q[k] + LEN_W'(1));
              grp_q[k] <= new_leader;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SYM; k++) begin : g_out
    assign bus.CNT[huff_sym_lo(k + 1, CNT_W) +: CNT_W]  = cnt_q[k];
    assign bus.HC[huff_sym_lo(k + 1, CODE_W) +: CODE_W] = hc_q[k];
    assign bus.M[huff_sym_lo(k + 1, CODE_W) +: CODE_W]  = m_q[k];
  end

endmodule

// File: tb/tb_huffman_gen.sv
// tb/tb_huffman_gen.sv - self-checking bench for huffman_gen
module tb_huffman_gen;

  localparam int NS = 6;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int KW = 8;
`ifdef HUFF_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  huffman_if #(.NUM_SYM(NS), .DATA_W(DW), .CNT_W(CW), .CODE_W(KW)) bus ();

  huffman_gen #(.NUM_SYM(NS), .DATA_W(DW), .CNT_W(CW), .CODE_W(KW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] samples[$];
  int            m_cnt[NS];
  logic [63:0]   e_cnt, e_hc, e_m;
  int            e_delay;
  logic [63:0]   obs_cnt, obs_hc, obs_m;
  int            obs_delay;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: histogram of the frame, then repeated pairing of the two lightest
  // live groups. Sort key w*NS + (NS-1-i) puts heavier weights later and, on a tie,
  // the higher symbol index first.
  task automatic build_model();
    int w[NS];
    int ld[NS];
    int ln[NS];
    logic [63:0] code[NS];
    int nact, a, b, ka, kb, key, nl, v;
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    foreach (samples[j]) begin
      v = int'(samples[j]);
      if (v >= 1 && v <= NS) begin
        if (SAT) m_cnt[v-1] = (m_cnt[v-1] == 255) ? 255 : m_cnt[v-1] + 1;
        else     m_cnt[v-1] = (m_cnt[v-1] + 1) % 256;
      end
    end
    nact = 0;
    for (int i = 0; i < NS; i++) begin
      w[i] = m_cnt[i]; ld[i] = i; ln[i] = 0; code[i] = '0;
      if (w[i] > 0) nact++;
    end
    for (int r = 0; r < NS; r++) begin
      a = -1; b = -1; ka = 0; kb = 0;
      for (int i = 0; i < NS; i++) begin
        key = w[i] * NS + (NS - 1 - i);
        if (ld[i] == i && w[i] > 0 && (a < 0 || key < ka)) begin a = i; ka = key; end
      end
      for (int i = 0; i < NS; i++) begin
        key = w[i] * NS + (NS - 1 - i);
        if (ld[i] == i && w[i] > 0 && i != a && (b < 0 || key < kb)) begin b = i; kb = key; end
      end
      if (b < 0) break;
      nl = (a < b) ? a : b;
      for (int s = 0; s < NS; s++) begin
        if (ld[s] == a) begin
          code[s] = code[s] | (64'd1 << ln[s]); ln[s]++; ld[s] = nl;
        end else if (ld[s] == b) begin
          ln[s]++; ld[s] = nl;
        end
      end
      w[nl] = w[a] + w[b];
    end
    e_cnt = '0; e_hc = '0; e_m = '0;
    for (int i = 0; i < NS; i++) begin
      e_cnt = e_cnt | (64'(m_cnt[i]) << (i * CW));
      e_hc  = e_hc  | (code[i] << (i * KW));
      e_m   = e_m   | (((64'd1 << ln[i]) - 64'd1) << (i * KW));
      if (nact == 1 && m_cnt[i] > 0) e_m = e_m | (64'd1 << (i * KW));
    end
    e_delay = (((nact > 1) ? nact : 1) - 1) * (NS + 1) + NS + 1;
  endtask

  task automatic shuffle_samples();
    logic [DW-1:0] t;
    int j;
    for (int i = samples.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = samples[i]; samples[i] = samples[j]; samples[j] = t;
    end
  endtask

  task automatic load_test1();
    int cnts[NS] = '{10, 5, 3, 2, 1, 1};
    samples.delete();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < cnts[s]; n++) samples.push_back(DW'(s + 1));
    shuffle_samples();
  endtask

  task automatic drive_samples();
    foreach (samples[j]) begin
      @(negedge clk);
      bus.gray_valid = 1'b1;
      bus.gray_data  = samples[j];
    end
  endtask

  task automatic run_frame(input string name, input bit inject);
    int c, d;
    bit seen;
    build_model();
    drive_samples();
    @(negedge clk);
    check({name, ".rec_busy"}, 64'(bus.busy), 64'd1);
    check({name, ".rec_cntv"}, 64'(bus.CNT_valid), 64'd0);
    bus.gray_valid = 1'b0;
    bus.gray_data  = '0;
    c = 0; seen = 0;
    while (c < 4 && !seen) begin
      @(negedge clk);
      c++;
      if (bus.CNT_valid) seen = 1;
    end
    check({name, ".cnt_lat"}, 64'(c), 64'd1);
    obs_cnt = 64'(bus.CNT);
    check({name, ".cnt"}, obs_cnt, e_cnt);
    d = 0; seen = 0;
    while (d < e_delay + 10 && !seen) begin
      @(negedge clk);
      d++;
      if (d == 1) check({name, ".cntv_pulse"}, 64'(bus.CNT_valid), 64'd0);
      if (bus.code_valid) seen = 1;
      else if (inject && (d == 2 || d == 3)) begin
        bus.gray_valid = 1'b1;
        bus.gray_data  = DW'($urandom_range(NS, 1));
      end else if (inject && d == 4) begin
        bus.gray_valid = 1'b0;
        bus.gray_data  = '0;
      end
    end
    obs_delay = d;
    check({name, ".code_lat"}, 64'(d), 64'(e_delay));
    obs_hc = 64'(bus.HC);
    obs_m  = 64'(bus.M);
    check({name, ".hc"}, obs_hc, e_hc);
    check({name, ".m"}, obs_m, e_m);
    check({name, ".cnt_hold"}, 64'(bus.CNT), e_cnt);
    check({name, ".done_busy"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({name, ".idle_busy"}, 64'(bus.busy), 64'd0);
    check({name, ".codev_pulse"}, 64'(bus.code_valid), 64'd0);
  endtask

  localparam logic [63:0] T1_HC = 64'h0000_0302_0001_0101;
  localparam logic [63:0] T1_M  = 64'h0000_1F1F_0F07_0301;

  initial begin
    int c, len, maxv;
    bus.gray_valid = 1'b0;
    bus.gray_data  = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst0.cnt", 64'(bus.CNT), 64'd0);
    check("rst0.hc", 64'(bus.HC), 64'd0);
    check("rst0.m", 64'(bus.M), 64'd0);
    check("rst0.busy", 64'(bus.busy), 64'd0);
    check("rst0.cntv", 64'(bus.CNT_valid), 64'd0);
    check("rst0.codev", 64'(bus.code_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // reference frame from the worked example
    load_test1();
    run_frame("t1", 1'b0);
    check("t1.hc_const", obs_hc, T1_HC);
    check("t1.m_const", obs_m, T1_M);
    check("t1.delay_const", 64'(obs_delay), 64'd42);

    // a single live symbol among ignored values
    samples = '{8'd0, 8'd3, 8'd9, 8'd3, 8'd0, 8'd3, 8'd9, 8'd3};
    run_frame("solo", 1'b0);
    check("solo.cnt_const", obs_cnt, 64'h0000_0000_0004_0000);
    check("solo.m_const", obs_m, 64'h0000_0000_0001_0000);
    check("solo.delay_const", 64'(obs_delay), 64'd7);

    // one-sample frame
    samples = '{8'd6};
    run_frame("one", 1'b0);

    // counter overflow behaviour
    samples.delete();
    for (int n = 0; n < 300; n++) samples.push_back(8'd1);
    run_frame("ovf", 1'b0);
    check("ovf.cnt1", 64'(obs_cnt[7:0]), SAT ? 64'd255 : 64'd44);

    // reset during the first scan pass, then a clean rebuild
    load_test1();
    drive_samples();
    @(negedge clk);
    bus.gray_valid = 1'b0;
    bus.gray_data  = '0;
    c = 0;
    while (c < 6 && !bus.CNT_valid) begin
      @(negedge clk);
      c++;
    end
    check("mid.cntv_seen", 64'(bus.CNT_valid), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid.cnt", 64'(bus.CNT), 64'd0);
    check("mid.hc", 64'(bus.HC), 64'd0);
    check("mid.m", 64'(bus.M), 64'd0);
    check("mid.busy", 64'(bus.busy), 64'd0);
    check("mid.codev", 64'(bus.code_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    load_test1();
    run_frame("post", 1'b0);
    check("post.hc_const", obs_hc, T1_HC);
    check("post.m_const", obs_m, T1_M);

    // stray samples while the tree is being built
    load_test1();
    run_frame("inj", 1'b1);
    check("inj.hc_const", obs_hc, T1_HC);
    check("inj.m_const", obs_m, T1_M);
    check("inj.cnt_const", obs_cnt, 64'h0000_0101_0203_050A);

    // random back-to-back frames
    for (int f = 0; f < 12; f++) begin
      samples.delete();
      len  = $urandom_range(40, 1);
      maxv = $urandom_range(9, 1);
      for (int n = 0; n < len; n++) samples.push_back(DW'($urandom_range(maxv, 0)));
      run_frame($sformatf("rnd%0d", f), 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
